cmp_arbiter: RTL and testbench

- Shares one signed `compare` instance (NUM_SIZE-wide, signed less/equal/greater outputs) between two requesters, e.g. the branch unit (req 0) and the SLT/SLTU ALU path (req 1).
- Per request: arbitrates, latches operands, maps the RV32I funct3 condition onto the signed comparator (unsigned via MSB inversion), and returns a registered 1-bit result over a valid/ready handshake.
- One transaction in flight at a time.

---
 rtl/cmp_arbiter.sv | 131 +++++++++++++
 tb/tb_cmp_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two requesters time-share one signed comparator.
// Unsigned conditions reuse it by flipping both operand MSBs.

module compare #(
    parameter int NUM_SIZE = 32
) (
    input  logic [NUM_SIZE-1:0] a,
    input  logic [NUM_SIZE-1:0] b,
    output logic                lessThan,
    output logic                equal,
    output logic                greaterThan
);
    assign lessThan    = $signed(a) < $signed(b);
    assign equal       = a == b;
    assign greaterThan = $signed(a) > $signed(b);
endmodule

module cmp_arbiter #(
    parameter int NUM_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [NUM_SIZE-1:0] req0_a,
    input  logic [NUM_SIZE-1:0] req0_b,
    input  logic [2:0]          req0_funct3,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [NUM_SIZE-1:0] req1_a,
    input  logic [NUM_SIZE-1:0] req1_b,
    input  logic [2:0]          req1_funct3,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_result,
    output logic                resp_id
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t state, stateNext;

    logic [NUM_SIZE-1:0] aLat, bLat;
    logic [NUM_SIZE-1:0] cmpA, cmpB, msbMask;
    logic [2:0]          f3Lat;
    logic                idLat, rrLast;
    logic                grant0, grant1, accept, acceptId;
    logic                flip, result;
    logic                lessThan, equal, greaterThan;
    logic                resultReg, idReg;

    // rrLast names the last winner; on a tie the other side wins
    assign grant0 = req0_valid & (~req1_valid | rrLast);
    assign grant1 = req1_valid & (~req0_valid | ~rrLast);

    assign req0_ready = (state == IDLE) & grant0 & ~rst;
    assign req1_ready = (state == IDLE) & grant1 & ~rst;
    assign accept     = req0_ready | req1_ready;
    assign acceptId   = req1_ready;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (accept) stateNext = CALC;
            CALC:    stateNext = RESP;
            RESP:    if (resp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aLat      <= '0;
            bLat      <= '0;
            f3Lat     <= '0;
            idLat     <= 1'b0;
            rrLast    <= 1'b1;
            resultReg <= 1'b0;
            idReg     <= 1'b0;
        end else begin
            if (accept) begin
                aLat   <= acceptId ? req1_a : req0_a;
                bLat   <= acceptId ? req1_b : req0_b;
                f3Lat  <= acceptId ? req1_funct3 : req0_funct3;
                idLat  <= acceptId;
                rrLast <= acceptId;
            end
            if (state == CALC) begin
                resultReg <= result;
                idReg     <= idLat;
            end
        end
    end

    // Flipping the sign bit turns signed order into unsigned order
    assign flip    = (f3Lat[2:1] == 2'b11) | (f3Lat == 3'b011);
    assign msbMask = {1'b1, {(NUM_SIZE-1){1'b0}}};
    assign cmpA    = aLat ^ (flip ? msbMask : '0);
    assign cmpB    = bLat ^ (flip ? msbMask : '0);

    compare #(.NUM_SIZE(NUM_SIZE)) uCompare (
        .a           (cmpA),
        .b           (cmpB),
        .lessThan    (lessThan),
        .equal       (equal),
        .greaterThan (greaterThan)
    );

    always_comb begin
        result = 1'b0;
        unique case (f3Lat)
            3'b000:  result = equal;
            3'b001:  result = ~equal;
            3'b010:  result = lessThan;
            3'b011:  result = lessThan;
            3'b100:  result = lessThan;
            3'b101:  result = greaterThan | equal;
            3'b110:  result = lessThan;
            3'b111:  result = greaterThan | equal;
            default: result = 1'b0;
        endcase
    end

    assign resp_valid  = (state == RESP);
    assign resp_result = resultReg;
    assign resp_id     = idReg;
endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: directed requests with literal expectations,
// plus a transaction-level model checked on every falling edge.

module tb_cmp_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0]  req0_funct3 = 0, req1_funct3 = 0;
    logic        resp_valid, resp_result, resp_id;
    logic        resp_ready = 1'b1;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(.NUM_SIZE(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_funct3 (req0_funct3),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_funct3 (req1_funct3),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_id     (resp_id)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Architectural meaning of each RV32I condition
    function automatic logic rule(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] f3);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2,
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd3,
            3'd6:    return a < b;
            default: return a >= b;
        endcase
    endfunction

    // Winner among current requests, or -1 when nobody asks
    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return 1 - last;
        if (v1)       return 1;
        if (v0)       return 0;
        return -1;
    endfunction

    // Transaction model: busy from accept until consumption,
    // response visible from the second edge after accept.
    bit   busy      = 0;
    int   age       = 0;
    int   lastGrant = 1;
    logic mRes      = 0;
    logic mId       = 0;

    always @(posedge clk) begin
        int w;
        w = pick(req0_valid, req1_valid, lastGrant);
        if (rst) begin
            busy      = 0;
            lastGrant = 1;
        end else if (!busy) begin
            if (w >= 0) begin
                busy      = 1;
                age       = 0;
                lastGrant = w;
                mId       = (w == 1);
                mRes      = (w == 1) ? rule(req1_a, req1_b, req1_funct3)
                                     : rule(req0_a, req0_b, req0_funct3);
            end
        end else if (age == 0) begin
            age = 1;
        end else if (resp_ready) begin
            busy = 0;
        end
    end

    always @(negedge clk) begin
        int  w;
        bit  canGrant;
        w        = pick(req0_valid, req1_valid, lastGrant);
        canGrant = !busy && !rst;
        check("m_ready0", req0_ready, canGrant && w == 0);
        check("m_ready1", req1_ready, canGrant && w == 1);
        check("m_valid", resp_valid, busy && age >= 1);
        if (busy && age >= 1) begin
            check("m_result", resp_result, mRes);
            check("m_id", resp_id, mId);
        end
    end

    task automatic waitReady(input int id, output bit ok);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic doReq(input int id, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] f3,
                         input logic expRes);
        bit ok;
        if (id == 0) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_funct3 = f3;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_funct3 = f3;
        end
        waitReady(id, ok);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        @(negedge clk);
        check("calc_novalid", resp_valid, 0);
        @(negedge clk);
        check("resp_valid", resp_valid, 1);
        check("resp_result", resp_result, expRes);
        check("resp_id", resp_id, id);
        @(posedge clk); #1;
    endtask

    initial begin
        int  order[4];
        int  got;
        bit  ok;

        @(negedge clk);
        check("rst_valid", resp_valid, 0);
        check("rst_result", resp_result, 0);
        check("rst_id", resp_id, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        @(posedge clk); #1;
        rst = 0;

        doReq(0, 32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b1);
        @(negedge clk);
        check("consumed", resp_valid, 0);
        @(posedge clk); #1;
        doReq(1, 32'hFFFFFFFF, 32'h00000001, 3'b110, 1'b0);
        doReq(1, 32'hFFFFFFFF, 32'h00000001, 3'b111, 1'b1);
        doReq(1, 32'h00000000, 32'h80000000, 3'b011, 1'b1);
        doReq(1, 32'h80000000, 32'h7FFFFFFF, 3'b010, 1'b1);
        doReq(0, 32'h12345678, 32'h12345678, 3'b000, 1'b1);
        doReq(0, 32'h12345678, 32'h12345678, 3'b001, 1'b0);
        doReq(0, 32'h12345678, 32'h12345678, 3'b101, 1'b1);
        doReq(0, 32'h12345678, 32'h12345678, 3'b100, 1'b0);

        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        req0_a = 5; req0_b = 5; req0_funct3 = 3'b000;
        req1_a = 1; req1_b = 2; req1_funct3 = 3'b010;
        req0_valid = 1;
        req1_valid = 1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            check("fair_onehot", req0_ready & req1_ready, 0);
            if (req0_ready)      order[got++] = 0;
            else if (req1_ready) order[got++] = 1;
            if (got == 4) begin
                @(posedge clk); #1;
                req0_valid = 0;
                req1_valid = 0;
            end
        end
        check("fair_count", got, 4);
        for (int i = 0; i < 4; i++) check("fair_order", order[i], i % 2);
        repeat (3) @(posedge clk);
        #1;

        resp_ready = 0;
        req0_a = 3; req0_b = 3; req0_funct3 = 3'b111;
        req0_valid = 1;
        waitReady(0, ok);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_a = 0; req1_b = 0; req1_funct3 = 3'b010;
        req1_valid = 1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", resp_valid, 1);
            check("stall_result", resp_result, 1);
            check("stall_id", resp_id, 0);
            check("stall_noready", req1_ready, 0);
        end
        @(posedge clk); #1;
        resp_ready = 1;
        @(negedge clk);
        check("stall_hold", resp_valid, 1);
        @(negedge clk);
        check("stall_next", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        repeat (3) @(posedge clk);
        #1;

        req0_a = 1; req0_b = 2; req0_funct3 = 3'b001;
        req0_valid = 1;
        waitReady(0, ok);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("abort_valid", resp_valid, 0);
        check("abort_ready0", req0_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("after_valid", resp_valid, 0);
        check("after_result", resp_result, 0);
        check("after_id", resp_id, 0);
        check("after_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("after_resp", resp_valid, 1);
        check("after_res", resp_result, 1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
